// File: rtl/hub75_scan_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : hub75_scan_ctrl
// Purpose  : HUB75 row scan sequencer with frame-swap sync and row prefetch.
//            Define HUB75_SCAN_STALL_EN to build the stat_stall counter.
// Revision : 1.0 - initial release
// =============================================================================
module hub75_scan_ctrl #(
   parameter int    N_ROWS     = 32,
   parameter string SCAN_MODE  = "ZIGZAG",
   parameter int    LOG_N_ROWS = $clog2(N_ROWS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ctrl_run,
   input  logic [7:0]            cfg_repeat,
   input  logic                  frame_swap,
   output logic                  frame_rdy,
   output logic                  fb_frame_swap,
   output logic [LOG_N_ROWS-1:0] fb_row_addr,
   output logic                  fb_row_load,
   input  logic                  fb_row_rdy,
   output logic                  fb_row_swap,
   output logic [LOG_N_ROWS-1:0] bcm_row,
   output logic                  bcm_row_first,
   output logic                  bcm_go,
   input  logic                  bcm_rdy,
   output logic [15:0]           stat_stall
);

   localparam logic [LOG_N_ROWS-1:0] c_last_row = LOG_N_ROWS'(N_ROWS - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_WAIT_FB = 3'd2,
      S_ISSUE   = 3'd3,
      S_DRAIN   = 3'd4
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [LOG_N_ROWS-1:0] r_idx, w_idx_nxt;
   logic [LOG_N_ROWS-1:0] w_order;
   logic [LOG_N_ROWS-1:0] r_bcm_row;
   logic                  r_bcm_row_first;
   logic [7:0]            r_pass, w_pass_nxt;
   logic [7:0]            r_repeat, w_repeat_nxt;
   logic                  r_pending;
   logic                  w_bcm_latch;

   // Row order is a bit rotation of the scan index for the non-linear modes.
   generate
      if (SCAN_MODE == "LINEAR") begin : g_linear
         assign w_order = r_idx;
      end else if (SCAN_MODE == "INTERLACE") begin : g_interlace
         assign w_order = {r_idx[LOG_N_ROWS-2:0], r_idx[LOG_N_ROWS-1]};
      end else begin : g_zigzag
         assign w_order = {r_idx[0], r_idx[LOG_N_ROWS-1:1]};
      end
   endgenerate

   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_pass_nxt    = r_pass;
      w_repeat_nxt  = r_repeat;
      w_bcm_latch   = 1'b0;
      fb_frame_swap = 1'b0;
      fb_row_load   = 1'b0;
      fb_row_swap   = 1'b0;
      bcm_go        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_pending) begin
               fb_frame_swap = 1'b1;
            end else if (ctrl_run && fb_row_rdy) begin
               w_state_nxt  = S_LOAD;
               w_idx_nxt    = '0;
               w_pass_nxt   = 8'd0;
               w_repeat_nxt = cfg_repeat;
            end
         end
         S_LOAD: begin
            fb_row_load = 1'b1;
            w_state_nxt = S_WAIT_FB;
         end
         S_WAIT_FB: begin
            if (fb_row_rdy && bcm_rdy) begin
               w_bcm_latch = 1'b1;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            fb_row_swap = 1'b1;
            bcm_go      = 1'b1;
            if (r_idx == c_last_row) begin
               w_state_nxt = S_DRAIN;
            end else begin
               w_idx_nxt   = r_idx + 1'b1;
               w_state_nxt = S_LOAD;
            end
         end
         S_DRAIN: begin
            if (bcm_rdy) begin
               if (r_pass < r_repeat) begin
                  w_pass_nxt  = r_pass + 8'd1;
                  w_idx_nxt   = '0;
                  w_state_nxt = S_LOAD;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // bcm_row is captured on leaving WAIT_FB so it is valid in the same cycle as bcm_go.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= S_IDLE;
         r_idx           <= '0;
         r_pass          <= 8'd0;
         r_repeat        <= 8'd0;
         r_pending       <= 1'b0;
         r_bcm_row       <= '0;
         r_bcm_row_first <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_idx    <= w_idx_nxt;
         r_pass   <= w_pass_nxt;
         r_repeat <= w_repeat_nxt;
         if (fb_frame_swap) begin
            r_pending <= 1'b0;
         end else if (frame_swap) begin
            r_pending <= 1'b1;
         end
         if (w_bcm_latch) begin
            r_bcm_row       <= w_order;
            r_bcm_row_first <= (r_idx == '0);
         end
      end
   end

   assign frame_rdy     = ~r_pending;
   assign fb_row_addr   = w_order;
   assign bcm_row       = r_bcm_row;
   assign bcm_row_first = r_bcm_row_first;

`ifdef HUB75_SCAN_STALL_EN
   logic [15:0] r_stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall <= 16'h0000;
      end else if ((r_state == S_WAIT_FB) && bcm_rdy && !fb_row_rdy && (r_stall != 16'hFFFF)) begin
         r_stall <= r_stall + 16'h0001;
      end
   end

   assign stat_stall = r_stall;
`else
   assign stat_stall = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hub75_scan_ctrl.sv
`default_nettype none
// Bench for hub75_scan_ctrl: three scan orders side by side, randomized
// latencies/repeats/swap requests checked against a row-order reference model.
module tb_hub75_scan_ctrl;

   localparam int N  = 8;
   localparam int H  = N / 2;
   localparam int LW = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, ctrl_run, frame_swap, fb_row_rdy, bcm_rdy;
   logic [7:0]    cfg_repeat;
   logic [2:0]    frame_rdy, fb_frame_swap, fb_row_load, fb_row_swap, bcm_row_first, bcm_go;
   logic [LW-1:0] fb_row_addr [3];
   logic [LW-1:0] bcm_row     [3];
   logic [15:0]   stat_stall  [3];

   hub75_scan_ctrl #(.N_ROWS(N), .SCAN_MODE("LINEAR")) u_lin (
      .clk(clk), .rst(rst), .ctrl_run(ctrl_run), .cfg_repeat(cfg_repeat), .frame_swap(frame_swap),
      .frame_rdy(frame_rdy[0]), .fb_frame_swap(fb_frame_swap[0]), .fb_row_addr(fb_row_addr[0]),
      .fb_row_load(fb_row_load[0]), .fb_row_rdy(fb_row_rdy), .fb_row_swap(fb_row_swap[0]),
      .bcm_row(bcm_row[0]), .bcm_row_first(bcm_row_first[0]), .bcm_go(bcm_go[0]),
      .bcm_rdy(bcm_rdy), .stat_stall(stat_stall[0]));

   hub75_scan_ctrl #(.N_ROWS(N), .SCAN_MODE("ZIGZAG")) u_zz (
      .clk(clk), .rst(rst), .ctrl_run(ctrl_run), .cfg_repeat(cfg_repeat), .frame_swap(frame_swap),
      .frame_rdy(frame_rdy[1]), .fb_frame_swap(fb_frame_swap[1]), .fb_row_addr(fb_row_addr[1]),
      .fb_row_load(fb_row_load[1]), .fb_row_rdy(fb_row_rdy), .fb_row_swap(fb_row_swap[1]),
      .bcm_row(bcm_row[1]), .bcm_row_first(bcm_row_first[1]), .bcm_go(bcm_go[1]),
      .bcm_rdy(bcm_rdy), .stat_stall(stat_stall[1]));

   hub75_scan_ctrl #(.N_ROWS(N), .SCAN_MODE("INTERLACE")) u_il (
      .clk(clk), .rst(rst), .ctrl_run(ctrl_run), .cfg_repeat(cfg_repeat), .frame_swap(frame_swap),
      .frame_rdy(frame_rdy[2]), .fb_frame_swap(fb_frame_swap[2]), .fb_row_addr(fb_row_addr[2]),
      .fb_row_load(fb_row_load[2]), .fb_row_rdy(fb_row_rdy), .fb_row_swap(fb_row_swap[2]),
      .bcm_row(bcm_row[2]), .bcm_row_first(bcm_row_first[2]), .bcm_go(bcm_go[2]),
      .bcm_rdy(bcm_rdy), .stat_stall(stat_stall[2]));

   // Framebuffer and BCM responders: busy for *_lat cycles after their strobe.
   int fb_lat = 3, bcm_lat = 3;
   int fb_cnt, bcm_cnt;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         fb_cnt  <= 0;
         bcm_cnt <= 0;
      end else begin
         if (fb_row_load[1])   fb_cnt  <= fb_lat;
         else if (fb_cnt > 0)  fb_cnt  <= fb_cnt - 1;
         if (bcm_go[1])        bcm_cnt <= bcm_lat;
         else if (bcm_cnt > 0) bcm_cnt <= bcm_cnt - 1;
      end
   end
   assign fb_row_rdy = (fb_cnt == 0);
   assign bcm_rdy    = (bcm_cnt == 0);

   int n_cmp = 0, n_err = 0;
   int issued = 0, loaded = 0, frame_total = 0, swaps_seen = 0, exp_stall = 0;
   bit waiting = 1'b0, exp_pending = 1'b0;

   function automatic int ref_order(int mode, int i);
      case (mode)
         0:       return i;
         1:       return (i % 2 == 0) ? i / 2 : H + i / 2;
         default: return (i < H) ? 2 * i : 2 * (i - H) + 1;
      endcase
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample at the falling edge and score every visible event.
   task automatic cyc();
      bit fs_req;
      int idx;
      fs_req = frame_swap;
      @(negedge clk);
      if (fs_req) exp_pending = 1'b1;
      for (int m = 0; m < 3; m++) begin
         chk("frame_rdy", frame_rdy[m], !exp_pending);
`ifdef HUB75_SCAN_STALL_EN
         chk("stat_stall", stat_stall[m], exp_stall);
`else
         chk("stat_stall_off", stat_stall[m], 0);
`endif
      end
      if (waiting && bcm_rdy && !fb_row_rdy && exp_stall < 65535) exp_stall++;
      if (bcm_go[1]) begin
         idx = issued % N;
         for (int m = 0; m < 3; m++) begin
            chk("bcm_go", bcm_go[m], 1);
            chk("fb_row_swap", fb_row_swap[m], 1);
            chk("bcm_row", bcm_row[m], ref_order(m, idx));
            chk("bcm_row_first", bcm_row_first[m], idx == 0);
         end
         issued++;
         waiting = 1'b0;
      end else if (fb_row_swap[1]) begin
         chk("fb_row_swap_alone", fb_row_swap[1], 0);
      end
      if (fb_row_load[1]) begin
         for (int m = 0; m < 3; m++) begin
            chk("fb_row_load", fb_row_load[m], 1);
            chk("fb_row_addr", fb_row_addr[m], ref_order(m, loaded % N));
         end
         loaded++;
         waiting = 1'b1;
      end
      if (fb_frame_swap[1]) begin
         chk("swap_requested", exp_pending, 1);
         chk("swap_after_frame", issued, frame_total);
         for (int m = 0; m < 3; m++) chk("fb_frame_swap", fb_frame_swap[m], 1);
         swaps_seen++;
         exp_pending = 1'b0;
      end
   endtask

   task automatic settle(int n);
      repeat (n) cyc();
   endtask

   task automatic pulse_swap();
      frame_swap = 1'b1;
      cyc();
      frame_swap = 1'b0;
   endtask

   task automatic start_frame(int rep);
      int base, b;
      base = loaded;
      b = 0;
      cfg_repeat  = 8'(rep);
      frame_total = frame_total + N * (rep + 1);
      ctrl_run    = 1'b1;
      while (loaded == base && b < 200) begin cyc(); b++; end
      chk("start_timeout", loaded != base, 1);
      ctrl_run   = 1'b0;
      cfg_repeat = 8'($urandom_range(4, 255));
   endtask

   task automatic wait_rows(int target, int budget);
      int b;
      b = 0;
      while (issued < target && b < budget) begin cyc(); b++; end
      chk("rows_timeout", issued, target);
   endtask

   task automatic check_reset_values(string tag);
      for (int m = 0; m < 3; m++) begin
         chk({tag, "_frame_rdy"}, frame_rdy[m], 1);
         chk({tag, "_bcm_row"}, bcm_row[m], 0);
         chk({tag, "_fb_row_addr"}, fb_row_addr[m], 0);
         chk({tag, "_stat_stall"}, stat_stall[m], 0);
      end
      chk({tag, "_strobes"}, {fb_frame_swap, fb_row_load, fb_row_swap, bcm_go}, 0);
      chk({tag, "_row_first"}, bcm_row_first, 0);
   endtask

   initial begin
      int sw0, rep, k, applied, start;
      rst = 1'b1; ctrl_run = 1'b0; frame_swap = 1'b0; cfg_repeat = 8'd0;
      settle(3);
      check_reset_values("reset");
      rst = 1'b0;
      settle(3);

      // Single pass, no repeats: full row order in each mode.
      start_frame(0);
      wait_rows(frame_total, 2000);
      settle(30);
      chk("passA_rows", issued, 8);

      // Repeat=2 with two swap requests mid-pass: one swap, after all 24 rows.
      sw0 = swaps_seen;
      start = issued;
      start_frame(2);
      wait_rows(start + 4, 2000);
      pulse_swap();
      settle(4);
      pulse_swap();
      chk("passB_not_ready", frame_rdy[1], 0);
      wait_rows(frame_total, 4000);
      settle(40);
      chk("passB_rows", issued - start, 24);
      chk("passB_swaps", swaps_seen - sw0, 1);
      chk("passB_frame_rdy", frame_rdy[1], 1);

      // Slow framebuffer relative to BCM exercises the starvation counter.
      fb_lat = 10; bcm_lat = 3;
      start_frame(0);
      wait_rows(frame_total, 2000);
      settle(20);

      // Randomized latencies, repeat counts and swap requests.
      for (int r = 0; r < 6; r++) begin
         fb_lat  = $urandom_range(1, 6);
         bcm_lat = $urandom_range(1, 6);
         rep     = $urandom_range(0, 3);
         sw0     = swaps_seen;
         start_frame(rep);
         k       = $urandom_range(0, 3);
         applied = 0;
         for (int p = 0; p < k; p++) begin
            settle($urandom_range(1, 8));
            if (issued < frame_total - 2) begin
               pulse_swap();
               applied++;
            end
         end
         wait_rows(frame_total, 4000);
         settle(40);
         chk("rnd_swaps", swaps_seen - sw0, applied > 0);
         chk("rnd_frame_rdy", frame_rdy[1], 1);
      end

      // Asynchronous reset while waiting on the framebuffer with a swap pending.
      fb_lat = 6; bcm_lat = 3;
      sw0 = swaps_seen;
      start_frame(0);
      pulse_swap();
      chk("pre_rst_pending", frame_rdy[1], 0);
      #2 rst = 1'b1;
      #1 check_reset_values("async_rst");
      exp_pending = 1'b0; exp_stall = 0; waiting = 1'b0;
      issued = 0; loaded = 0; frame_total = 0;
      settle(2);
      rst = 1'b0;
      settle(30);
      chk("rst_swap_discarded", swaps_seen - sw0, 0);
      chk("rst_no_rows", issued, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
